// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: datapath sizes, saturation
// limits and the controller state encoding.
package nibble_serial_adder_pkg;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = 4;
  localparam int NIB_W   = 4;

  // Index of the most significant nibble; the run ends after processing it.
  localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);

  localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/CLA_4bit.sv
// 4-bit carry-lookahead adder used once per cycle on the current nibble.
module CLA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms with carries expanded in lookahead form.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// 16-bit two's-complement add/subtract computed one nibble per clock through a
// single 4-bit adder, with optional signed saturation and Z/V/N flags.
//
// Handshake: ready is high only in IDLE; a start seen high on a rising edge
// while ready=1 is accepted on that edge. start at any other time is ignored.
// done pulses for exactly one cycle, in which Sum and flags already hold the
// new result; they stay unchanged until the next done.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Z,
  output logic             V,
  output logic             N,
  output state_t           dbg_state
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [1:0]       idx;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] cla_s;
  logic             cla_co;

  logic [WIDTH-1:0] raw_sum;
  logic             raw_ovf;
  logic [WIDTH-1:0] fin_sum;

  CLA_4bit u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (cla_s),
    .cout (cla_co)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; ready depends on state only so it is 1 during reset.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // Nibble select and final-result shaping. The top nibble is not yet in res
  // on the closing edge, so the raw sum splices in the live adder output.
  always_comb begin
    nib_a          = opa[{idx, 2'b00} +: NIB_W];
    nib_b          = opb[{idx, 2'b00} +: NIB_W];
    raw_sum        = res;
    raw_sum[15:12] = cla_s;
    raw_ovf        = (opa[15] == opb[15]) && (raw_sum[15] != opa[15]);
    fin_sum        = raw_sum;
    if ((SATURATE != 0) && raw_ovf) begin
      fin_sum = opa[15] ? SAT_NEG : SAT_POS;
    end
  end

  // Operand capture, per-nibble accumulation and result/flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      Sum   <= '0;
      Z     <= 1'b0;
      V     <= 1'b0;
      N     <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= A;
            opb   <= B ^ {WIDTH{sub}};
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          res[{idx, 2'b00} +: NIB_W] <= cla_s;
          carry                      <= cla_co;
          if (idx == LAST_IDX) begin
            Sum  <= fin_sum;
            V    <= raw_ovf;
            Z    <= (fin_sum == '0);
            N    <= fin_sum[15];
            done <= 1'b1;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter SATURATE, default 1, meaning 1 = clamp signed overflow and 0 = wrap modulo 2^16.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request, sampled on the rising clk edge.
REQ-005 SHALL have port A  input  16  first operand, two's complement.
REQ-006 SHALL have port B  input  16  second operand, two's complement.
REQ-007 SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-008 SHALL have port ready  output  1  high only in IDLE; start is accepted only then.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking that Sum and flags are valid and updated.
REQ-010 SHALL have port Sum  output  16  registered result, held until the next done.
REQ-011 SHALL have ports Z, V, N  output  1 each  zero, signed-overflow and negative flags; registered and updated only with done.

Function
REQ-012 SHALL use states IDLE, RUN and DONE.
REQ-013 SHALL treat start=1 in IDLE at edge T as acceptance, and on that edge:
- latch A into opA;
- latch B XOR {16{sub}} into opB;
- load the carry register with sub;
- clear the nibble index to 0;
- go to RUN.
REQ-014 SHALL, in RUN, add one nibble per cycle, nibble 0 (bits 3:0) first:
- feed opA nibble, opB nibble and the carry register to a single 4-bit adder;
- write the 4-bit sum into the result register at that nibble position;
- register the adder carry-out for the next nibble.
REQ-015 SHALL process nibbles 0..3 in cycles T+1..T+4, then go to DONE; the index increments by 1 each RUN cycle and never wraps past 3.
REQ-016 SHALL, on the edge leaving RUN, compute raw overflow = (opA[15] == opB[15]) AND (raw sum bit 15 != opA[15]).
REQ-017 SHALL, with SATURATE=1 and overflow, update Sum to 0x7FFF when opA[15]=0 and to 0x8000 when opA[15]=1; otherwise Sum is updated to the raw sum.
REQ-018 SHALL set, on that same edge, V = raw overflow (independent of SATURATE), Z = (updated Sum == 0) and N = updated Sum[15].
REQ-019 SHALL assert done during cycle T+5 only (state DONE), then return to IDLE; ready returns high in cycle T+6.
REQ-020 SHALL ignore start while in RUN or DONE: operands are not re-latched and the in-flight result is not altered.
REQ-021 SHALL not accept a start in DONE; a start held high through DONE is accepted in the first IDLE cycle.
REQ-022 SHALL keep ready purely state-decoded, so ready=1 while rst_n is low.
REQ-023 SHALL produce no X on any output after reset, regardless of A, B or sub.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force:
- state = IDLE;
- Sum = 0, Z = 0, V = 0, N = 0, done = 0;
- opA, opB, carry register and nibble index = 0.
REQ-025 SHALL, on reset asserted mid-RUN or in DONE, abort the operation with no done pulse and restart cleanly from IDLE on deassertion.

Structure
REQ-026 SHALL place the state encoding (IDLE/RUN/DONE typedef), NIBBLES=4, WIDTH=16, SAT_POS=0x7FFF and SAT_NEG=0x8000 in the shared processor package.
REQ-027 SHALL instantiate exactly one sub-module, CLA_4bit, as the per-nibble adder; carry chaining between nibbles goes only through the registered carry.

Verification
REQ-028 SHALL cover: A=0x1234, B=0x0FCD, sub=0, start at T -> done in T+5, Sum=0x2201, Z=0, V=0, N=0.
REQ-029 SHALL cover: A=0x7FFF, B=0x0001, sub=0 -> Sum=0x7FFF, V=1, N=0; same operands with SATURATE=0 -> Sum=0x8000, V=1, N=1.
REQ-030 SHALL cover: A=0x8000, B=0x0001, sub=1 -> Sum=0x8000, V=1, N=1, Z=0.
REQ-031 SHALL cover: A=0x00FF, B=0x00FF, sub=1 -> carry propagates through all nibbles, Sum=0x0000, Z=1, V=0, N=0.
REQ-032 SHALL cover: start with A=0x0001, B=0x0001 at T; start with A=0x1111, B=0x1111 at T+2 -> done in T+5, Sum=0x0002; second request ignored; ready=0 in T+1..T+5.
REQ-033 SHALL cover: rst_n low in T+3 of an operation -> ready=1 immediately, no done, Sum/flags=0; a start after deassertion completes normally 5 cycles later.
